// File: rtl/clk_step_ctrl.sv
// Clock-enable controller for the processor core: fast/slow run, debounced single-step and halt,
// plus the legacy free-running divclock/depclock square waves, heartbeat LEDs and tick counter.
module clk_step_ctrl #(
    parameter int FAST_DIV   = 64,
    parameter int SLOW_DIV   = 65536,
    parameter int DEB_CYCLES = 500000,
    parameter int HB_W       = 28,
    parameter int LED_W      = 4,
    parameter int TC_W       = 32
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              step_btn,
    output logic              tick,
    output logic              divclock,
    output logic              depclock,
    output logic [LED_W-1:0]  LEDR,
    output logic [TC_W-1:0]   tick_count,
    output logic [1:0]        mode_q
);

    localparam logic [1:0] MODE_FAST = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int RW      = $clog2(MAX_DIV);
    localparam int FW      = $clog2(FAST_DIV);
    localparam int SW      = $clog2(SLOW_DIV);
    localparam int DW      = $clog2(DEB_CYCLES + 1);

    localparam logic [RW-1:0] RATE_FAST_LAST = RW'(FAST_DIV - 1);
    localparam logic [RW-1:0] RATE_SLOW_LAST = RW'(SLOW_DIV - 1);
    localparam logic [FW-1:0] DIV_LAST       = FW'(FAST_DIV - 1);
    localparam logic [FW-1:0] DIV_HALF       = FW'(FAST_DIV / 2);
    localparam logic [SW-1:0] DEP_LAST       = SW'(SLOW_DIV - 1);
    localparam logic [SW-1:0] DEP_HALF       = SW'(SLOW_DIV / 2);
    localparam logic [DW-1:0] DEB_LAST       = DW'(DEB_CYCLES - 1);

    logic [1:0]      mode_s1;
    logic [1:0]      mode_prev;
    logic            mode_chg;
    logic            run_mode;
    logic            run_wrap;
    logic [RW-1:0]   rate_cnt;
    logic [RW-1:0]   rate_last;
    logic [RW-1:0]   rate_nxt;

    logic            btn_s1;
    logic            btn_s2;
    logic [DW-1:0]   deb_cnt;
    logic            deb_level;
    logic            deb_prev;
    logic            step_rise;
    logic            step_tick;
    logic            tick_nxt;

    logic [FW-1:0]   div_cnt;
    logic [FW-1:0]   div_nxt;
    logic [SW-1:0]   dep_cnt;
    logic [SW-1:0]   dep_nxt;
    logic [HB_W-1:0] hb_cnt;

    // A mode change restarts the period from zero so the core never sees a short tick interval.
    always_comb begin
        mode_chg  = (mode_q != mode_prev);
        run_mode  = ~mode_q[1];
        rate_last = (mode_q == MODE_FAST) ? RATE_FAST_LAST : RATE_SLOW_LAST;
        run_wrap  = run_mode & ~mode_chg & (rate_cnt == rate_last);

        rate_nxt = rate_cnt + RW'(1);
        if (~run_mode || mode_chg || (rate_cnt == rate_last)) begin
            rate_nxt = '0;
        end

        step_rise = deb_level & ~deb_prev;
        step_tick = step_rise & (mode_q == MODE_STEP);
        tick_nxt  = (run_wrap | step_tick) & ~tick;

        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + FW'(1);
        dep_nxt = (dep_cnt == DEP_LAST) ? '0 : dep_cnt + SW'(1);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mode_s1    <= '0;
            mode_q     <= '0;
            mode_prev  <= '0;
            rate_cnt   <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else begin
            mode_s1   <= mode;
            mode_q    <= mode_s1;
            mode_prev <= mode_q;
            rate_cnt  <= rate_nxt;
            tick      <= tick_nxt;
            if (tick_nxt) begin
                tick_count <= tick_count + TC_W'(1);
            end
        end
    end

    // Debouncer: level is accepted only after DEB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            deb_cnt   <= '0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
        end else begin
            btn_s1   <= step_btn;
            btn_s2   <= btn_s1;
            deb_prev <= deb_level;
            if (btn_s2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= btn_s2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            dep_cnt  <= '0;
            divclock <= 1'b0;
            depclock <= 1'b0;
            hb_cnt   <= '0;
        end else begin
            div_cnt  <= div_nxt;
            dep_cnt  <= dep_nxt;
            divclock <= (div_nxt >= DIV_HALF);
            depclock <= (dep_nxt >= DEP_HALF);
            hb_cnt   <= hb_cnt + HB_W'(1);
        end
    end

    assign LEDR = hb_cnt[HB_W-1 -: LED_W];

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: table-driven run-mode vectors plus hand sequences for mode change,
// step debounce, halt presses and mid-run reset; ticks are scored against a queue of expected cycles.
module tb_clk_step_ctrl;

    localparam int FD = 4;
    localparam int SD = 8;
    localparam int DB = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] mode     = 2'b00;
    logic       step_btn = 1'b0;
    logic       tick;
    logic       divclock;
    logic       depclock;
    logic [3:0] LEDR;
    logic [7:0] tick_count;
    logic [1:0] mode_q;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];
    logic prev_tick = 1'b0;

    clk_step_ctrl #(
        .FAST_DIV(FD), .SLOW_DIV(SD), .DEB_CYCLES(DB),
        .HB_W(6), .LED_W(4), .TC_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .mode(mode), .step_btn(step_btn),
        .tick(tick), .divclock(divclock), .depclock(depclock), .LEDR(LEDR),
        .tick_count(tick_count), .mode_q(mode_q)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0] mode;
        int         cycles;
        int         first;
        int         period;
        int         exp_tc;
    } run_vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge CLOCK_50);
        reset    = 1'b1;
        mode     = m;
        step_btn = 1'b0;
        exp_q.delete();
        #1;
        check("reset_outputs", int'({tick, divclock, depclock, LEDR, tick_count, mode_q}), 0);
        @(negedge CLOCK_50);
        cyc   = 0;
        reset = 1'b0;
    endtask

    // Scoreboard and free-running checks, sampled 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (!reset) begin
                cyc++;
                check("divclock", int'(divclock), ((cyc % FD) >= FD / 2) ? 1 : 0);
                check("depclock", int'(depclock), ((cyc % SD) >= SD / 2) ? 1 : 0);
                check("LEDR", int'(LEDR), (cyc % 64) / 4);
                if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                    check("expected_tick", int'(tick), 1);
                    void'(exp_q.pop_front());
                end else if (tick) begin
                    check("unexpected_tick", 1, 0);
                end
                if (tick) begin
                    check("tick_back_to_back", int'(prev_tick), 0);
                end
                prev_tick = tick;
            end else begin
                prev_tick = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run_vec_t vecs[5];
        int       t0;

        vecs[0] = '{2'b00, 12,   4,  4, 3};
        vecs[1] = '{2'b01, 27,   11, 8, 3};
        vecs[2] = '{2'b11, 20,   0,  0, 0};
        vecs[3] = '{2'b10, 20,   0,  0, 0};
        vecs[4] = '{2'b00, 1040, 4,  4, 4};

        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].mode);
            if (vecs[i].period > 0) begin
                for (int t = vecs[i].first; t <= vecs[i].cycles; t += vecs[i].period) begin
                    exp_q.push_back(t);
                end
            end
            run_cycles(vecs[i].cycles);
            check("vec_tick_count", int'(tick_count), vecs[i].exp_tc);
            check("vec_mode_q", int'(mode_q), int'(vecs[i].mode));
            check("vec_pending_ticks", exp_q.size(), 0);
        end

        // Fast to slow mid-period: change takes effect after sync, period restarts from zero.
        do_reset(2'b00);
        exp_q.push_back(4);
        exp_q.push_back(16);
        exp_q.push_back(24);
        exp_q.push_back(32);
        run_cycles(5);
        mode = 2'b01;
        run_cycles(1);
        check("mode_q_before_sync", int'(mode_q), 0);
        run_cycles(1);
        check("mode_q_after_sync", int'(mode_q), 1);
        run_cycles(26);
        check("modechg_tick_count", int'(tick_count), 4);
        check("modechg_pending", exp_q.size(), 0);

        // Bouncing press in step mode: one tick, 2 sync + DB stable + 1 output cycle after the hold starts.
        do_reset(2'b10);
        run_cycles(4);
        step_btn = 1'b1; run_cycles(1);
        step_btn = 1'b0; run_cycles(1);
        step_btn = 1'b1; run_cycles(1);
        step_btn = 1'b0; run_cycles(1);
        t0 = cyc + 1;
        exp_q.push_back(t0 + 2 + DB);
        step_btn = 1'b1; run_cycles(20);
        step_btn = 1'b0; run_cycles(12);
        check("step_tick_count", int'(tick_count), 1);
        check("step_pending", exp_q.size(), 0);

        // Presses in halt are dropped; entering step with the button held gives nothing until re-press.
        do_reset(2'b11);
        run_cycles(2);
        for (int p = 0; p < 5; p++) begin
            step_btn = 1'b1; run_cycles(8);
            step_btn = 1'b0; run_cycles(8);
        end
        check("halt_tick_count", int'(tick_count), 0);
        step_btn = 1'b1; run_cycles(10);
        mode = 2'b10;    run_cycles(10);
        check("held_mode_q", int'(mode_q), 2);
        check("held_tick_count", int'(tick_count), 0);
        step_btn = 1'b0; run_cycles(10);
        t0 = cyc + 1;
        exp_q.push_back(t0 + 2 + DB);
        step_btn = 1'b1; run_cycles(12);
        step_btn = 1'b0; run_cycles(10);
        check("repress_tick_count", int'(tick_count), 1);
        check("repress_pending", exp_q.size(), 0);

        // Reset mid-period: partial period discarded, first tick a full period after release.
        do_reset(2'b00);
        exp_q.push_back(4);
        run_cycles(5);
        check("pre_reset_tick_count", int'(tick_count), 1);
        check("pre_reset_pending", exp_q.size(), 0);
        do_reset(2'b00);
        exp_q.push_back(4);
        exp_q.push_back(8);
        run_cycles(8);
        check("post_reset_tick_count", int'(tick_count), 2);
        check("post_reset_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
